wb_commit_arbiter: RTL and testbench

// - Parametrised writeback stage: collects results from NUM_SRC execution sources (ALU, LSU, MUL/DIV, CSR, ...),

---
 rtl/wb_commit_arbiter_pkg.sv | 13 +
 rtl/wb_commit_arbiter_if.sv | 30 +++
 rtl/wb_commit_arbiter_src_fifo.sv | 61 ++++++
 rtl/wb_commit_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_commit_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_commit_arbiter_pkg.sv
// Shared types and widths for the writeback commit arbiter.
package wb_commit_arbiter_pkg;

    localparam int unsigned WB_RD_W = 5;
    localparam int unsigned WB_XLEN = 32;

    // One buffered result waiting for a register-file write port.
    typedef struct packed {
        logic [WB_RD_W-1:0] rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_commit_arbiter_if.sv
// Source handshake and register-file write-port bundle of the commit arbiter.
interface wb_commit_arbiter_if
    import wb_commit_arbiter_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned NUM_WP  = 1
);

    logic [NUM_SRC-1:0]         src_valid_i;
    logic [NUM_SRC-1:0]         src_ready_o;
    logic [NUM_SRC*WB_RD_W-1:0] src_rd_i;
    logic [NUM_SRC*XLEN-1:0]    src_data_i;
    logic [NUM_WP-1:0]          rf_we_o;
    logic [NUM_WP*WB_RD_W-1:0]  rf_waddr_o;
    logic [NUM_WP*XLEN-1:0]     rf_wdata_o;

    // Execution sources and register-file consumer side.
    modport master (
        output src_valid_i, src_rd_i, src_data_i,
        input  src_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o
    );

    // Arbiter side.
    modport slave (
        input  src_valid_i, src_rd_i, src_data_i,
        output src_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o
    );

endinterface

// File: rtl/wb_commit_arbiter_src_fifo.sv
// Per-source result FIFO; extra pointer MSB distinguishes full from empty.
module wb_commit_arbiter_src_fifo
    import wb_commit_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      flush_i,
    input  logic      push_i,
    input  wb_entry_t entry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    wb_entry_t        mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (wr_q[IDX_W] != rd_q[IDX_W]) && (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign head_o  = mem_q[rd_q[IDX_W-1:0]];
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Pointer next-state; flush empties the FIFO outright.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_W'(1);
            if (do_pop)  rd_d = rd_q + PTR_W'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[IDX_W-1:0]] <= entry_i;
    end

endmodule

// File: rtl/wb_commit_arbiter.sv
// Writeback stage: per-source FIFOs round-robin arbitrated onto registered RF write ports.
module wb_commit_arbiter
    import wb_commit_arbiter_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned NUM_WP    = 1,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                hold_i,
    wb_commit_arbiter_if.slave  wb_if,
    output logic                busy_o
);

    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned SUM_W = SRC_W + 1;

    logic [NUM_SRC-1:0] full, empty, push, pop;
    wb_entry_t          head [NUM_SRC];

    logic [SRC_W-1:0]                  rr_q, rr_d;
    logic [NUM_WP-1:0]                 port_vld;
    logic [NUM_WP-1:0][WB_RD_W-1:0]    port_rd;
    logic [NUM_WP-1:0][XLEN-1:0]       port_data;
    logic [NUM_WP-1:0]                 we_q;
    logic [NUM_WP-1:0][WB_RD_W-1:0]    waddr_q;
    logic [NUM_WP-1:0][XLEN-1:0]       wdata_q;

    // Source FIFOs; results for x0 are swallowed at the push.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        wb_entry_t entry;
        assign entry.rd   = wb_if.src_rd_i[i*WB_RD_W +: WB_RD_W];
        assign entry.data = WB_XLEN'(wb_if.src_data_i[i*XLEN +: XLEN]);
        assign push[i]    = wb_if.src_valid_i[i] && !full[i] && (entry.rd != '0) && !flush_i;

        wb_commit_arbiter_src_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (push[i]),
            .entry_i (entry),
            .pop_i   (pop[i]),
            .head_o  (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );
    end

    assign wb_if.src_ready_o = ~full;
    assign busy_o            = |(~empty);

    // Round-robin scan from rr_q; stop at the first rd collision or once every port is taken.
    always_comb begin
        logic             stop;
        logic             conflict;
        logic             placed;
        logic             any_grant;
        logic [SUM_W-1:0] sum;
        logic [SRC_W-1:0] idx;
        logic [SRC_W-1:0] last_idx;
        pop       = '0;
        port_vld  = '0;
        port_rd   = '0;
        port_data = '0;
        rr_d      = rr_q;
        stop      = 1'b0;
        conflict  = 1'b0;
        placed    = 1'b0;
        any_grant = 1'b0;
        sum       = '0;
        idx       = '0;
        last_idx  = '0;
        if (!flush_i && !hold_i) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                sum = {1'b0, rr_q} + SUM_W'(k);
                if (sum >= SUM_W'(NUM_SRC)) sum = sum - SUM_W'(NUM_SRC);
                idx = SRC_W'(sum);
                if (!stop && !empty[idx]) begin
                    conflict = 1'b0;
                    for (int unsigned p = 0; p < NUM_WP; p++) begin
                        if (port_vld[p] && (port_rd[p] == head[idx].rd)) conflict = 1'b1;
                    end
                    if (conflict || (&port_vld)) begin
                        stop = 1'b1;
                    end else begin
                        placed = 1'b0;
                        for (int unsigned p = 0; p < NUM_WP; p++) begin
                            if (!placed && !port_vld[p]) begin
                                port_vld[p]  = 1'b1;
                                port_rd[p]   = head[idx].rd;
                                port_data[p] = XLEN'(head[idx].data);
                                placed       = 1'b1;
                            end
                        end
                        pop[idx]  = 1'b1;
                        any_grant = 1'b1;
                        last_idx  = idx;
                    end
                end
            end
            if (any_grant) begin
                rr_d = (last_idx == SRC_W'(NUM_SRC - 1)) ? '0 : last_idx + SRC_W'(1);
            end
        end
    end

    // Registered write ports and round-robin pointer; idle ports keep their last address/data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q    <= '0;
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rr_q <= rr_d;
            we_q <= port_vld;
            for (int unsigned p = 0; p < NUM_WP; p++) begin
                if (port_vld[p]) begin
                    waddr_q[p] <= port_rd[p];
                    wdata_q[p] <= port_data[p];
                end
            end
        end
    end

    assign wb_if.rf_we_o    = we_q;
    assign wb_if.rf_waddr_o = waddr_q;
    assign wb_if.rf_wdata_o = wdata_q;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Directed bench for wb_commit_arbiter: one NUM_WP=1 and one NUM_WP=2 instance.
module tb_wb_commit_arbiter;

    logic clk;
    logic rst_n;
    logic flush;
    logic hold;
    logic busy1, busy2;
    int   n_tests;
    int   n_fail;

    wb_commit_arbiter_if #(.XLEN(32), .NUM_SRC(4), .NUM_WP(1)) bus1 ();
    wb_commit_arbiter_if #(.XLEN(32), .NUM_SRC(4), .NUM_WP(2)) bus2 ();

    wb_commit_arbiter #(.XLEN(32), .NUM_SRC(4), .NUM_WP(1), .BUF_DEPTH(2)) u_dut1 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .hold_i  (hold),
        .wb_if   (bus1),
        .busy_o  (busy1)
    );

    wb_commit_arbiter #(.XLEN(32), .NUM_SRC(4), .NUM_WP(2), .BUF_DEPTH(2)) u_dut2 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .hold_i  (hold),
        .wb_if   (bus2),
        .busy_o  (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_src();
        bus1.src_valid_i = '0;
        bus1.src_rd_i    = '0;
        bus1.src_data_i  = '0;
        bus2.src_valid_i = '0;
        bus2.src_rd_i    = '0;
        bus2.src_data_i  = '0;
    endtask

    task automatic drv1(input int s, input logic [4:0] rd, input logic [31:0] d);
        bus1.src_valid_i[s]        = 1'b1;
        bus1.src_rd_i[s*5 +: 5]    = rd;
        bus1.src_data_i[s*32 +: 32] = d;
    endtask

    task automatic drv2(input int s, input logic [4:0] rd, input logic [31:0] d);
        bus2.src_valid_i[s]        = 1'b1;
        bus2.src_rd_i[s*5 +: 5]    = rd;
        bus2.src_data_i[s*32 +: 32] = d;
    endtask

    initial begin
        logic [4:0]  exp_rd   [4];
        logic [31:0] exp_data [4];
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        hold    = 1'b0;
        clr_src();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_busy1", busy1, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_we", bus1.rf_we_o, 0);
        chk("rst_waddr", bus1.rf_waddr_o, 0);
        chk("rst_wdata", bus1.rf_wdata_o, 0);
        chk("rst_ready", bus1.src_ready_o, 4'hF);
        chk("rst_we2", bus2.rf_we_o, 0);

        // All four sources at once, twice; rr stays at 0 so order is rd 1,2,3,4 both times
        for (int rep = 0; rep < 2; rep++) begin
            for (int s = 0; s < 4; s++) drv1(s, 5'(s + 1), 32'h100 + 32'(s));
            tick();
            clr_src();
            chk("all4_busy", busy1, 1);
            chk("all4_we_early", bus1.rf_we_o, 0);
            for (int j = 0; j < 4; j++) begin
                tick();
                chk("all4_we", bus1.rf_we_o, 1);
                chk("all4_waddr", bus1.rf_waddr_o, 64'(j + 1));
                chk("all4_wdata", bus1.rf_wdata_o, 64'h100 + 64'(j));
            end
            tick();
            chk("all4_we_done", bus1.rf_we_o, 0);
            chk("all4_busy_done", busy1, 0);
        end

        // Single result: visible two edges after the push, exactly once
        drv1(0, 5'd5, 32'hDEAD_BEEF);
        tick();
        clr_src();
        chk("single_we_n1", bus1.rf_we_o, 0);
        chk("single_busy", busy1, 1);
        tick();
        chk("single_we", bus1.rf_we_o, 1);
        chk("single_waddr", bus1.rf_waddr_o, 5);
        chk("single_wdata", bus1.rf_wdata_o, 32'hDEAD_BEEF);
        chk("single_busy_after", busy1, 0);
        tick();
        chk("single_we_once", bus1.rf_we_o, 0);
        chk("single_waddr_hold", bus1.rf_waddr_o, 5);

        // Fairness: last grant was src0, so the scan now starts at src1 -> rd 2,3,4,1
        exp_rd[0] = 5'd2; exp_data[0] = 32'h201;
        exp_rd[1] = 5'd3; exp_data[1] = 32'h202;
        exp_rd[2] = 5'd4; exp_data[2] = 32'h203;
        exp_rd[3] = 5'd1; exp_data[3] = 32'h200;
        for (int s = 0; s < 4; s++) drv1(s, 5'(s + 1), 32'h200 + 32'(s));
        tick();
        clr_src();
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("fair_we", bus1.rf_we_o, 1);
            chk("fair_waddr", bus1.rf_waddr_o, exp_rd[j]);
            chk("fair_wdata", bus1.rf_wdata_o, exp_data[j]);
        end
        tick();
        chk("fair_we_done", bus1.rf_we_o, 0);

        // rd=0 is accepted and discarded
        drv1(2, 5'd0, 32'h55);
        #1;
        chk("rd0_ready_pre", bus1.src_ready_o, 4'hF);
        tick();
        chk("rd0_ready", bus1.src_ready_o, 4'hF);
        chk("rd0_busy", busy1, 0);
        clr_src();
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("rd0_we", bus1.rf_we_o, 0);
            chk("rd0_busy_later", busy1, 0);
        end

        // Fill src0 under hold, then flush with a concurrent push
        hold = 1'b1;
        drv1(0, 5'd9, 32'hA);
        tick();
        chk("fill1_ready", bus1.src_ready_o, 4'hF);
        drv1(0, 5'd10, 32'hB);
        tick();
        clr_src();
        chk("fill2_ready", bus1.src_ready_o, 4'hE);
        chk("fill2_busy", busy1, 1);
        chk("fill2_we", bus1.rf_we_o, 0);
        tick();
        chk("hold_ready", bus1.src_ready_o, 4'hE);
        chk("hold_we", bus1.rf_we_o, 0);
        flush = 1'b1;
        drv1(1, 5'd3, 32'hC);
        tick();
        flush = 1'b0;
        clr_src();
        chk("flush_ready", bus1.src_ready_o, 4'hF);
        chk("flush_busy", busy1, 0);
        chk("flush_we", bus1.rf_we_o, 0);
        hold = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("flush_no_retire", bus1.rf_we_o, 0);
        end

        // NUM_WP=2 WAW: both target rd7, src1 must wait a cycle
        drv2(0, 5'd7, 32'h11);
        drv2(1, 5'd7, 32'h22);
        tick();
        clr_src();
        chk("waw_we_n1", bus2.rf_we_o, 0);
        tick();
        chk("waw_we_k", bus2.rf_we_o, 2'b01);
        chk("waw_waddr_k", bus2.rf_waddr_o, 10'h007);
        chk("waw_wdata_k", bus2.rf_wdata_o, 64'h0000_0000_0000_0011);
        tick();
        chk("waw_we_k1", bus2.rf_we_o, 2'b01);
        chk("waw_wdata_k1", bus2.rf_wdata_o, 64'h0000_0000_0000_0022);
        tick();
        chk("waw_we_done", bus2.rf_we_o, 0);
        chk("waw_busy_done", busy2, 0);

        // NUM_WP=2 distinct rds: both ports in one cycle, lowest port first from rr=2
        drv2(2, 5'd3, 32'h33);
        drv2(3, 5'd4, 32'h44);
        tick();
        clr_src();
        tick();
        chk("dual_we", bus2.rf_we_o, 2'b11);
        chk("dual_waddr", bus2.rf_waddr_o, {5'd4, 5'd3});
        chk("dual_wdata", bus2.rf_wdata_o, {32'h44, 32'h33});
        tick();
        chk("dual_we_done", bus2.rf_we_o, 0);

        // Asynchronous reset with three results still buffered (rr=1 -> rd12 retires first)
        for (int s = 0; s < 4; s++) drv1(s, 5'(11 + s), 32'hA0 + 32'(s));
        tick();
        clr_src();
        chk("arst_busy_pre", busy1, 1);
        tick();
        chk("arst_we_pre", bus1.rf_we_o, 1);
        chk("arst_waddr_pre", bus1.rf_waddr_o, 12);
        chk("arst_wdata_pre", bus1.rf_wdata_o, 32'hA1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", bus1.rf_we_o, 0);
        chk("arst_busy", busy1, 0);
        chk("arst_waddr", bus1.rf_waddr_o, 0);
        chk("arst_ready", bus1.src_ready_o, 4'hF);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("arst_no_retire", bus1.rf_we_o, 0);
            chk("arst_busy_after", busy1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
